// File: rtl/pcr_pkg.sv
// pcr_pkg: shared widths, message layout constants and FSM state encoding for the PCR extend block
package pcr_pkg;
  localparam int DIGEST_W = 160;
  localparam int WORD_W = 64;
  localparam int MSG_WORDS = 5;
  localparam int RESETTABLE_BASE = 16;
  typedef logic [DIGEST_W-1:0] pcr_t;
  typedef enum logic [2:0] {IDLE, SHARST, WRITE, START, WAIT, STORE} state_t;
endpackage

// File: rtl/pcr_bank.sv
// pcr_bank: reset-to-zero PCR register array with one write port, one registered read port and an unregistered tap
module pcr_bank import pcr_pkg::*; #(
  parameter int NUM_PCRS = 24,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  pcr_t             wdata,
  input  logic [IDX_W-1:0] raddr,
  output pcr_t             rdata,
  input  logic [IDX_W-1:0] caddr,
  output pcr_t             cdata
);
  localparam logic [IDX_W:0] NUM = (IDX_W+1)'(NUM_PCRS);
  pcr_t mem_q [NUM_PCRS];
  pcr_t mem_d [NUM_PCRS];
  pcr_t rdata_q, rdata_d;
  // next array contents and read data; out-of-range addresses write nothing and read zero
  always_comb begin
    mem_d = mem_q;
    if (we && {1'b0, waddr} < NUM) mem_d[waddr] = wdata;
    rdata_d = {1'b0, raddr} < NUM ? mem_q[raddr] : '0;
  end
  // array and read register, cleared while reset is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= '{default: '0};
      rdata_q <= '0;
    end else begin
      mem_q <= mem_d;
      rdata_q <= rdata_d;
    end
  end
  assign rdata = rdata_q;
  assign cdata = {1'b0, caddr} < NUM ? mem_q[caddr] : '0;
endmodule

// File: rtl/pcr_extend.sv
// pcr_extend: PCR bank plus SHA1 extend sequencer; PCR_RESET_EN adds a resetReq port that zeroes PCRs 16 and up
module pcr_extend import pcr_pkg::*; #(
  parameter int NUM_PCRS = 24,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             extendReq,
`ifdef PCR_RESET_EN
  input  logic             resetReq,
`endif
  input  logic [IDX_W-1:0] pcrIndex,
  input  pcr_t             measurement,
  output logic             busy,
  output logic             done,
  output logic             error,
  input  logic [IDX_W-1:0] readIndex,
  output pcr_t             readValue,
  output logic [WORD_W-1:0] shaData,
  output logic [7:0]       shaLen,
  output logic             shaWrite,
  output logic             shaStart,
  output logic             shaReset,
  input  pcr_t             shaDigest,
  input  logic             shaReady
);
  localparam int MSG_W = WORD_W * MSG_WORDS;
  localparam logic [IDX_W:0] NUM = (IDX_W+1)'(NUM_PCRS);
  localparam logic [2:0] LAST = 3'(MSG_WORDS - 1);
`ifdef PCR_RESET_EN
  localparam logic [IDX_W-1:0] BASE = IDX_W'(RESETTABLE_BASE);
`endif
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d, waddr;
  logic [MSG_W-1:0] msg_q, msg_d;
  pcr_t dig_q, dig_d, wdata, cur;
  logic [WORD_W-1:0] data_q, data_d;
  logic [7:0] len_q, len_d;
  logic rdy_q, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic write_q, write_d, start_q, start_d, sha_reset_q, sha_reset_d;
  logic we, valid, ack, err;
  pcr_bank #(.NUM_PCRS(NUM_PCRS), .IDX_W(IDX_W)) u_bank (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr(readIndex), .rdata(readValue), .caddr(pcrIndex), .cdata(cur)
  );
  assign valid = {1'b0, pcrIndex} < NUM;
  // sequencer next state; outputs are decoded from the next state so they line up with the state register
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    msg_d = msg_q;
    dig_d = dig_q;
    we = 1'b0;
    waddr = idx_q;
    wdata = dig_q;
    ack = 1'b0;
    err = 1'b0;
    case (state_q)
      IDLE: if (extendReq) begin
        idx_d = pcrIndex;
        msg_d = {cur, measurement};
        state_d = valid ? SHARST : IDLE;
        ack = !valid;
        err = !valid;
      end
`ifdef PCR_RESET_EN
      else if (resetReq) begin
        ack = 1'b1;
        err = !(valid && pcrIndex >= BASE);
        we = !err;
        waddr = pcrIndex;
        wdata = '0;
      end
`endif
      SHARST: begin
        state_d = WRITE;
        cnt_d = '0;
      end
      WRITE: begin
        cnt_d = cnt_q + 3'd1;
        state_d = cnt_q == LAST ? START : WRITE;
      end
      START: state_d = WAIT;
      WAIT: if (shaReady && !rdy_q) begin
        dig_d = shaDigest;
        state_d = STORE;
      end
      STORE: begin
        we = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    write_d = state_d == WRITE;
    if (write_d) msg_d = {msg_q[MSG_W-WORD_W-1:0], {WORD_W{1'b0}}};
    data_d = write_d ? msg_q[MSG_W-1 -: WORD_W] : '0;
    len_d = write_d ? 8'(WORD_W) : '0;
    start_d = state_d == START;
    sha_reset_d = state_d == SHARST;
    busy_d = state_d != IDLE;
    done_d = ack || state_d == STORE;
    error_d = err;
  end
  // state and registered outputs; reset holds the SHA1 core in reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      msg_q <= '0;
      dig_q <= '0;
      rdy_q <= 1'b0;
      data_q <= '0;
      len_q <= '0;
      write_q <= 1'b0;
      start_q <= 1'b0;
      sha_reset_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      msg_q <= msg_d;
      dig_q <= dig_d;
      rdy_q <= shaReady;
      data_q <= data_d;
      len_q <= len_d;
      write_q <= write_d;
      start_q <= start_d;
      sha_reset_q <= sha_reset_d;
      busy_q <= busy_d;
      done_q <= done_d;
      error_q <= error_d;
    end
  end
  assign shaData = data_q;
  assign shaLen = len_q;
  assign shaWrite = write_q;
  assign shaStart = start_q;
  assign shaReset = sha_reset_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_pcr_extend.sv
// tb_pcr_extend: directed table-driven bench for pcr_extend with a behavioural SHA1 core and SHA1 reference model
module tb_pcr_extend;
  import pcr_pkg::*;
  logic clk = 1'b0, reset = 1'b0, extendReq = 1'b0;
  logic [4:0] pcrIndex = '0, readIndex = '0;
  pcr_t measurement = '0, readValue;
  pcr_t shaDigest = '0;
  logic shaReady = 1'b0;
  logic busy, done, error, shaWrite, shaStart, shaReset;
  logic [63:0] shaData;
  logic [7:0] shaLen;
`ifdef PCR_RESET_EN
  logic resetReq = 1'b0;
`endif
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  pcr_extend dut (
    .clk(clk), .reset(reset), .extendReq(extendReq),
`ifdef PCR_RESET_EN
    .resetReq(resetReq),
`endif
    .pcrIndex(pcrIndex), .measurement(measurement), .busy(busy), .done(done), .error(error),
    .readIndex(readIndex), .readValue(readValue), .shaData(shaData), .shaLen(shaLen),
    .shaWrite(shaWrite), .shaStart(shaStart), .shaReset(shaReset),
    .shaDigest(shaDigest), .shaReady(shaReady)
  );

  function automatic logic [159:0] sha1_320(input logic [319:0] m);
    logic [511:0] blk;
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    blk = {m, 8'h80, 120'h0, 64'd320};
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 80; i++) begin
      t = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin f = (b & c) | (~b & d); k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d; k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else begin f = b ^ c ^ d; k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a + 32'h67452301, b + 32'hEFCDAB89, c + 32'h98BADCFE, d + 32'h10325476, e + 32'hC3D2E1F0};
  endfunction

  // behavioural SHA1 core: collects writes, answers 4 cycles after start; ready is left high afterwards
  logic [63:0] sbuf [5];
  int wi = 0, scnt = 0;
  always @(posedge clk) begin
    if (shaReset) begin
      wi <= 0;
      scnt <= 0;
    end else begin
      if (shaWrite && wi < 5) begin sbuf[wi] <= shaData; wi <= wi + 1; end
      if (shaStart) begin scnt <= 4; shaReady <= 1'b0; end
      else if (scnt == 1) begin
        scnt <= 0;
        shaReady <= 1'b1;
        shaDigest <= sha1_320({sbuf[0], sbuf[1], sbuf[2], sbuf[3], sbuf[4]});
      end else if (scnt > 1) scnt <= scnt - 1;
    end
  end

  logic [63:0] wlog [$];
  int len_bad = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (shaWrite) begin
      wlog.push_back(shaData);
      if (shaLen != 8'd64) len_bad <= len_bad + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_op(input logic [4:0] idx, input pcr_t m, output logic got_done, output logic got_err);
    extendReq = 1'b1; pcrIndex = idx; measurement = m;
    @(negedge clk);
    extendReq = 1'b0;
    got_done = 1'b0; got_err = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      if (done) begin got_done = 1'b1; got_err = error; end
      else @(negedge clk);
    end
  endtask

  task automatic rd(input logic [4:0] idx, output pcr_t v);
    readIndex = idx;
    @(negedge clk);
    v = readValue;
  endtask

  typedef struct { logic [4:0] idx; pcr_t m; logic err; } vec_t;
  vec_t tbl [6];
  pcr_t pcr_m [24];
  pcr_t m0, prev, v;
  logic [63:0] ew [5];
  logic gd, ge, found;
  int n, d0;

  initial begin
    m0 = 160'h0123_1357_6789_abcd_6666_7777_8888_9999_a864_ca86;
    tbl[0] = '{5'd3,  160'h1111_2222_3333_4444_5555_6666_7777_8888_9999_aaaa, 1'b0};
    tbl[1] = '{5'd24, 160'hdead_beef_0000_0000_0000_0000_0000_0000_0000_0001, 1'b1};
    tbl[2] = '{5'd31, 160'hffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 1'b1};
    tbl[3] = '{5'd23, 160'h0f0f_0f0f_f0f0_f0f0_1234_5678_9abc_def0_0000_ffff, 1'b0};
    tbl[4] = '{5'd3,  160'h0000_0000_0000_0000_0000_0000_0000_0000_0000_0000, 1'b0};
    tbl[5] = '{5'd0,  160'ha5a5_5a5a_a5a5_5a5a_a5a5_5a5a_a5a5_5a5a_a5a5_5a5a, 1'b0};
    for (int i = 0; i < 24; i++) pcr_m[i] = '0;

    repeat (3) @(negedge clk);
    chk("rst_shaReset", 160'(shaReset), 160'(1));
    chk("rst_busy", 160'(busy), '0);
    chk("rst_done", 160'(done), '0);
    chk("rst_shaWrite", 160'(shaWrite), '0);
    chk("rst_shaData", 160'(shaData), '0);
    reset = 1'b1;
    rd(5'd0, v);
    chk("rst_read0", v, '0);

    wlog.delete();
    do_op(5'd0, m0, gd, ge);
    chk("x1_done", 160'(gd), 160'(1));
    chk("x1_error", 160'(ge), '0);
    ew = '{64'h0, 64'h0, 64'h0000_0000_0123_1357, 64'h6789_abcd_6666_7777, 64'h8888_9999_a864_ca86};
    chk("x1_nwords", 160'(wlog.size()), 160'(5));
    for (int i = 0; i < 5; i++) chk($sformatf("x1_word%0d", i), 160'(i < wlog.size() ? wlog[i] : 64'hx), 160'(ew[i]));
    pcr_m[0] = sha1_320({160'h0, m0});
    @(negedge clk);
    chk("x1_busy_fall", 160'(busy), '0);
    rd(5'd0, v);
    chk("x1_pcr0", v, pcr_m[0]);

    prev = pcr_m[0];
    wlog.delete();
    do_op(5'd0, m0, gd, ge);
    chk("x2_done", 160'(gd), 160'(1));
    ew = '{prev[159:96], prev[95:32], {prev[31:0], m0[159:128]}, m0[127:64], m0[63:0]};
    for (int i = 0; i < 5; i++) chk($sformatf("x2_word%0d", i), 160'(i < wlog.size() ? wlog[i] : 64'hx), 160'(ew[i]));
    pcr_m[0] = sha1_320({prev, m0});
    @(negedge clk);
    chk("x2_read_old", readValue, prev);
    @(negedge clk);
    chk("x2_read_new", readValue, pcr_m[0]);

    for (int t = 0; t < 6; t++) begin
      n = wlog.size();
      do_op(tbl[t].idx, tbl[t].m, gd, ge);
      chk($sformatf("tbl%0d_done", t), 160'(gd), 160'(1));
      chk($sformatf("tbl%0d_error", t), 160'(ge), 160'(tbl[t].err));
      chk($sformatf("tbl%0d_writes", t), 160'(wlog.size()), 160'(tbl[t].err ? n : n + 5));
      if (!tbl[t].err) pcr_m[tbl[t].idx] = sha1_320({pcr_m[tbl[t].idx], tbl[t].m});
      @(negedge clk);
      chk($sformatf("tbl%0d_busy", t), 160'(busy), '0);
    end
    for (int i = 0; i < 24; i++) begin
      rd(5'(i), v);
      chk($sformatf("bank_pcr%0d", i), v, pcr_m[i]);
    end
    rd(5'd24, v);
    chk("read_oob", v, '0);

    d0 = done_cnt;
    extendReq = 1'b1; pcrIndex = 5'd1; measurement = m0;
    @(negedge clk);
    extendReq = 1'b0;
    repeat (3) @(negedge clk);
    extendReq = 1'b1; pcrIndex = 5'd5;
    @(negedge clk);
    extendReq = 1'b0;
    repeat (25) @(negedge clk);
    chk("drop_done_count", 160'(done_cnt - d0), 160'(1));
    pcr_m[1] = sha1_320({pcr_m[1], m0});
    rd(5'd5, v);
    chk("drop_pcr5", v, '0);
    rd(5'd1, v);
    chk("drop_pcr1", v, pcr_m[1]);

    extendReq = 1'b1; pcrIndex = 5'd2; measurement = m0;
    @(negedge clk);
    extendReq = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = shaStart;
    end
    chk("rw_start_seen", 160'(found), 160'(1));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rw_busy", 160'(busy), '0);
    chk("rw_shaReset", 160'(shaReset), 160'(1));
    reset = 1'b1;
    for (int i = 0; i < 24; i++) pcr_m[i] = '0;
    rd(5'd0, v);
    chk("rw_pcr0_zero", v, '0);
    do_op(5'd0, m0, gd, ge);
    chk("rw_redo_done", 160'(gd), 160'(1));
    pcr_m[0] = sha1_320({160'h0, m0});
    @(negedge clk);
    rd(5'd0, v);
    chk("rw_redo_pcr0", v, pcr_m[0]);
    rd(5'd2, v);
    chk("rw_pcr2_zero", v, '0);

`ifdef PCR_RESET_EN
    do_op(5'd16, m0, gd, ge);
    @(negedge clk);
    pcr_m[16] = sha1_320({160'h0, m0});
    rd(5'd16, v);
    chk("rr_pcr16_ext", v, pcr_m[16]);
    do_op(5'd3, m0, gd, ge);
    @(negedge clk);
    pcr_m[3] = sha1_320({160'h0, m0});
    resetReq = 1'b1; pcrIndex = 5'd16;
    @(negedge clk);
    resetReq = 1'b0;
    chk("rr16_done", 160'(done), 160'(1));
    chk("rr16_error", 160'(error), '0);
    rd(5'd16, v);
    chk("rr16_zero", v, '0);
    resetReq = 1'b1; pcrIndex = 5'd3;
    @(negedge clk);
    resetReq = 1'b0;
    chk("rr3_done", 160'(done), 160'(1));
    chk("rr3_error", 160'(error), 160'(1));
    rd(5'd3, v);
    chk("rr3_kept", v, pcr_m[3]);
`endif

    chk("shaLen_64", 160'(len_bad), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
